// File: rtl/edge_cnt_pkg.sv
// edge_cnt_pkg: state encoding and default sizes shared by the edge-counting controller.
package edge_cnt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/edge_cnt_ctrl_edge_detect.sv
// edge_detect: two-stage input buffer with combinational rising-edge flag.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic buff,
  output logic rise
);
  logic buff_q, buff_d, prev_q, prev_d;
  always_comb begin
    buff_d = in_i;
    prev_d = buff_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buff_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      buff_q <= buff_d;
      prev_q <= prev_d;
    end
  end
  assign buff = buff_q;
  assign rise = buff_q & ~prev_q;
endmodule

// File: rtl/edge_cnt_ctrl.sv
// edge_cnt_ctrl: counts rising edges of a buffered input up to a latched target.
// Define EDGE_CNT_TIMEOUT_EN to end a run after TIMEOUT cycles without an edge.
module edge_cnt_ctrl
  import edge_cnt_pkg::*;
#(
  parameter int W = W_DEF
`ifdef EDGE_CNT_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] target,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [W-1:0] count,
  output logic         buff
);
  state_t state_q, state_d;
  logic [W-1:0] tgt_q, tgt_d, cnt_q, cnt_d;
  logic rise;
  edge_detect u_edge_detect (.clk(clk), .rst_n(rst_n), .in_i(in), .buff(buff), .rise(rise));
`ifdef EDGE_CNT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic to_q, to_d, expired;
  // the cycle whose increment would reach TIMEOUT ends the run instead
  assign expired = (idle_q == IW'(TIMEOUT - 1));
`endif
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
`ifdef EDGE_CNT_TIMEOUT_EN
    idle_d  = idle_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        tgt_d   = target;
        cnt_d   = '0;
        state_d = (target == '0) ? DONE : COUNT;
`ifdef EDGE_CNT_TIMEOUT_EN
        idle_d  = '0;
        to_d    = 1'b0;
`endif
      end
      COUNT: if (abort) state_d = IDLE;
      else if (rise) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == tgt_q) ? DONE : COUNT;
`ifdef EDGE_CNT_TIMEOUT_EN
        idle_d  = '0;
      end else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end else begin
        idle_d  = idle_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
`ifdef EDGE_CNT_TIMEOUT_EN
      idle_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
`ifdef EDGE_CNT_TIMEOUT_EN
      idle_q  <= idle_d;
      to_q    <= to_d;
`endif
    end
  end
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign count = cnt_q;
`ifdef EDGE_CNT_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif
endmodule
